fft_bitrev_reorder: RTL and testbench

Output reorder buffer for the streaming FFT pipeline. The radix-2 delay-feedback stages emit each frame of 2^N_LOG2 complex samples in bit-reversed index order; this block collects a frame and reads it out in natural order. It uses ping-pong banks, so one frame can be written while the previous frame drains. It sits after the last butterfly/delay stage and before the downstream consumer, with valid/ready flow control on both sides.

---
 rtl/fft_bitrev_reorder.sv | 152 +++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order frame reorder buffer with ping-pong banks.
// The writer fills one bank in bit-reversed order while the reader drains the
// other bank in natural order through a one-deep output register.
module fft_bitrev_reorder #(
    parameter int unsigned N_LOG2 = 4,
    parameter int unsigned WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned N  = 1 << N_LOG2;
    localparam int unsigned AW = N_LOG2;
    localparam int unsigned CW = N_LOG2 + 1;

    typedef enum logic {WR_FILL, WR_HOLD}  wr_state_t;
    typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

    wr_state_t        wr_state;
    wr_state_t        wr_next;
    rd_state_t        rd_state;
    rd_state_t        rd_next;
    logic             wr_bank;
    logic [AW-1:0]    wr_cnt;
    logic [CW-1:0]    rd_addr;

    logic [WIDTH-1:0] mem [2][N];

    logic             accept;
    logic [AW-1:0]    wr_idx;
    logic             wr_last;
    logic             rd_busy;
    logic             rd_load;
    logic             rd_fin;
    logic             rd_free;
    logic             swap;
    logic             rd_bank;

    // Reverse the address bits of a beat index.
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int b = 0; b < int'(AW); b++) begin
            r[b] = a[int'(AW) - 1 - b];
        end
        return r;
    endfunction

    // Next-state logic for both FSMs, bank swap and read-register load.
    always_comb begin
        wr_next = wr_state;
        rd_next = rd_state;
        swap    = 1'b0;

        accept  = in_valid && in_ready;
        wr_idx  = in_sof ? '0 : wr_cnt;
        wr_last = accept && (wr_idx == AW'(N - 1));
        rd_bank = ~wr_bank;

        // Reader still needs its bank until the last address has been loaded.
        rd_busy = (rd_state == RD_DRAIN) && (rd_addr != CW'(N));
        rd_load = rd_busy && (!out_valid || out_ready);
        rd_fin  = rd_load && (rd_addr == CW'(N - 1));
        rd_free = !rd_busy || rd_fin;

        unique case (wr_state)
            WR_FILL: begin
                if (wr_last) begin
                    if (rd_free) begin
                        swap = 1'b1;
                    end else begin
                        wr_next = WR_HOLD;
                    end
                end
            end
            WR_HOLD: begin
                if (rd_free) begin
                    swap    = 1'b1;
                    wr_next = WR_FILL;
                end
            end
            default: wr_next = WR_FILL;
        endcase

        if (swap) begin
            rd_next = RD_DRAIN;
        end else if ((rd_state == RD_DRAIN) && !rd_busy && out_valid && out_ready) begin
            rd_next = RD_IDLE;
        end
    end

    // Control state, counters and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_FILL;
            rd_state <= RD_IDLE;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_addr  <= '0;
            in_ready <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            in_ready <= (wr_next == WR_FILL);
            if (swap) begin
                wr_bank <= ~wr_bank;
            end
            if (accept) begin
                wr_cnt <= wr_last ? '0 : wr_idx + AW'(1);
            end
            if (swap) begin
                rd_addr <= '0;
            end else if (rd_load) begin
                rd_addr <= rd_addr + CW'(1);
            end
        end
    end

    // Bank storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][bitrev(wr_idx)] <= in_data;
        end
    end

    // One-deep output register; fields change only when it loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_data  <= '0;
        end else if (rd_load) begin
            out_valid <= 1'b1;
            out_sof   <= (rd_addr == CW'(0));
            out_eof   <= (rd_addr == CW'(N - 1));
            out_data  <= mem[rd_bank][rd_addr[AW-1:0]];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: an input monitor builds expected
// natural-order frames from accepted beats, an output monitor checks them.
module tb_fft_bitrev_reorder;

    localparam int N_LOG2 = 4;
    localparam int N      = 16;
    localparam int W      = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sof = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_sof;
    logic         out_eof;
    logic [W-1:0] out_data;

    fft_bitrev_reorder #(.N_LOG2(N_LOG2), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_eof(out_eof), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        logic         e;
    } exp_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           stalls = 0;
    int           out_mode = 1;   // 0: hold low, 1: always high, 2: random
    exp_t         exp_q[$];
    logic [W-1:0] outlog[$];
    int           outcyc[$];
    logic [W-1:0] fbuf[N];
    int           fill = 0;
    logic         ph = 1'b0;
    logic [W-1:0] pd = '0;
    logic         ps = 1'b0;
    logic         pe = 1'b0;
    int           t1_exp[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rev(input int a);
        int r = 0;
        for (int b = 0; b < N_LOG2; b++) r = r * 2 + ((a >> b) & 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        @(negedge clk);
        while (!in_ready) begin
            stalls++;
            n++;
            if (n > 1000) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 || out_valid) begin
            n++;
            if (n > limit) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: pending=%0d after %0d cycles, expected 0", exp_q.size(), n);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Consumer ready generator.
    initial forever begin
        @(posedge clk);
        #1;
        case (out_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: collect accepted beats, emit natural-order frame.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            fill = 0;
        end else if (in_valid && in_ready) begin
            if (in_sof) fill = 0;
            fbuf[fill] = in_data;
            fill++;
            if (fill == N) begin
                for (int a = 0; a < N; a++) begin
                    exp_t e;
                    e.d = fbuf[rev(a)];
                    e.s = (a == 0);
                    e.e = (a == N - 1);
                    exp_q.push_back(e);
                end
                fill = 0;
            end
        end
    end

    // Output monitor: scoreboard compare and hold-stability check.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            ph = 1'b0;
        end else begin
            if (ph) begin
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_data", out_data, pd);
                check("hold_sof", W'(out_sof), W'(ps));
                check("hold_eof", W'(out_eof), W'(pe));
            end
            if (out_valid && out_ready) begin
                outlog.push_back(out_data);
                outcyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected no output", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e.d);
                    check("sb_sof", W'(out_sof), W'(e.s));
                    check("sb_eof", W'(out_eof), W'(e.e));
                end
            end
            ph = out_valid && !out_ready;
            pd = out_data;
            ps = out_sof;
            pe = out_eof;
        end
    end

    initial begin
        int base;
        int st;
        int lim;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, W'(0));
        check("rst_out_sof", W'(out_sof), W'(0));
        check("rst_out_eof", W'(out_eof), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready_before_edge", W'(in_ready), W'(0));
        @(negedge clk);
        check("rel_in_ready_after_edge", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        // 1: single frame, latency and natural order
        out_mode = 1;
        base = outlog.size();
        for (int i = 0; i < N; i++) send_beat(W'(i), i == 0);
        @(negedge clk);
        check("t1_valid_low_at_k", W'(out_valid), W'(0));
        @(negedge clk);
        check("t1_valid_at_k1", W'(out_valid), W'(1));
        check("t1_first_data", out_data, W'(0));
        check("t1_first_sof", W'(out_sof), W'(1));
        wait_idle(200);
        check("t1_count", W'(outlog.size() - base), W'(N));
        if (outlog.size() - base >= N)
            for (int i = 0; i < N; i++) check("t1_order", outlog[base + i], W'(t1_exp[i]));

        // 2: three back-to-back frames
        @(posedge clk);
        #1;
        base = outlog.size();
        st = stalls;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++) send_beat(W'(f * N + i), i == 0);
        wait_idle(300);
        check("t2_no_stall", W'(stalls - st), W'(0));
        check("t2_count", W'(outlog.size() - base), W'(3 * N));
        if (outlog.size() - base >= 3 * N) begin
            check("t2_gapless", W'(outcyc[base + 3 * N - 1] - outcyc[base]), W'(3 * N - 1));
            check("t2_f2_first", outlog[base + N], W'(16));
            check("t2_f2_second", outlog[base + N + 1], W'(24));
        end

        // 3: backpressure with second frame behind a stalled first frame
        out_mode = 0;
        @(posedge clk);
        #1;
        base = outlog.size();
        for (int i = 0; i < N; i++) send_beat(W'(i), i == 0);
        for (int i = 0; i < N; i++) send_beat(W'(N + i), i == 0);
        @(negedge clk);
        check("t3_in_ready_low", W'(in_ready), W'(0));
        check("t3_out_valid", W'(out_valid), W'(1));
        check("t3_out_data_held", out_data, W'(0));
        check("t3_out_sof_held", W'(out_sof), W'(1));
        repeat (5) @(negedge clk);
        check("t3_in_ready_still_low", W'(in_ready), W'(0));
        check("t3_out_data_still", out_data, W'(0));
        out_mode = 1;
        wait_idle(300);
        check("t3_count", W'(outlog.size() - base), W'(2 * N));
        check("t3_in_ready_back", W'(in_ready), W'(1));

        // 4: random ready toggling and input gaps over 10 frames
        out_mode = 2;
        @(posedge clk);
        #1;
        base = outlog.size();
        for (int f = 0; f < 10; f++)
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                send_beat(W'($urandom), i == 0);
            end
        wait_idle(3000);
        check("t4_count", W'(outlog.size() - base), W'(10 * N));
        out_mode = 1;

        // 5: in_sof resync drops partial frame
        @(posedge clk);
        #1;
        base = outlog.size();
        for (int i = 0; i < 5; i++) send_beat(W'(50 + i), i == 0);
        for (int i = 0; i < N; i++) send_beat(W'(100 + i), i == 0);
        wait_idle(200);
        check("t5_count", W'(outlog.size() - base), W'(N));
        if (outlog.size() - base >= 2) begin
            check("t5_first", outlog[base], W'(100));
            check("t5_second", outlog[base + 1], W'(108));
        end

        // 6: reset during drain
        @(posedge clk);
        #1;
        base = outlog.size();
        for (int i = 0; i < N; i++) send_beat(W'($urandom), i == 0);
        lim = 0;
        while (outlog.size() - base < 7 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        check("t6_reached_beat7", W'(outlog.size() - base), W'(7));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_valid_drop", W'(out_valid), W'(0));
        check("t6_async_data_clear", out_data, W'(0));
        check("t6_in_ready_low", W'(in_ready), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = outlog.size();
        for (int i = 0; i < N; i++) send_beat(W'(1000 + i), i == 0);
        wait_idle(200);
        check("t6_count", W'(outlog.size() - base), W'(N));
        if (outlog.size() - base >= 1) check("t6_first", outlog[base], W'(1000));

        check("final_queue_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
